// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: round-robin between ALU (A) and load (B)
// sources, registered write stage, and per-register pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [ADDR_WIDTH-1:0]    issue_rd,
  input  logic                     a_valid,
  input  logic [ADDR_WIDTH-1:0]    a_rd,
  input  logic [DATA_WIDTH-1:0]    a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [ADDR_WIDTH-1:0]    b_rd,
  input  logic [DATA_WIDTH-1:0]    b_data,
  output logic                     b_ready,
  output logic [ADDR_WIDTH-1:0]    rf_write_reg,
  output logic [DATA_WIDTH-1:0]    rf_write_data,
  output logic                     rf_reg_write_en,
  output logic [2**ADDR_WIDTH-1:0] busy
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic                  last_b_q, last_b_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]       busy_q, busy_d;

  // last_b_q=1 means B was granted last, so A wins a contested cycle
  assign a_ready = !rst && a_valid && (!b_valid || last_b_q);
  assign b_ready = !rst && b_valid && (!a_valid || !last_b_q);

  // a staged write is dropped combinationally when reset arrives
  assign rf_reg_write_en = we_q && !rst;
  assign rf_write_reg    = wreg_q;
  assign rf_write_data   = wdata_q;
  assign busy            = busy_q;

  always_comb begin
    last_b_d = last_b_q;
    we_d     = 1'b0;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    busy_d   = busy_q;
    unique case (1'b1)
      a_ready: begin
        last_b_d = 1'b0;
        if (a_rd != '0) begin
          we_d    = 1'b1;
          wreg_d  = a_rd;
          wdata_d = a_data;
        end
      end
      b_ready: begin
        last_b_d = 1'b1;
        if (b_rd != '0) begin
          we_d    = 1'b1;
          wreg_d  = b_rd;
          wdata_d = b_data;
        end
      end
      default: ;
    endcase
    if (rf_reg_write_en) busy_d[wreg_q] = 1'b0;
    // set after clear: a freshly issued producer wins
    if (issue_valid && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_q <= 1'b1;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
    end else begin
      last_b_q <= last_b_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed plan plus random traffic,
// scoreboard queue of expected writes checked by an independent monitor.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        a_valid = 1'b0;
  logic [4:0]  a_rd = '0;
  logic [63:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [4:0]  b_rd = '0;
  logic [63:0] b_data = '0;
  logic        b_ready;
  logic [4:0]  rf_write_reg;
  logic [63:0] rf_write_data;
  logic        rf_reg_write_en;
  logic [31:0] busy;

  regfile_wb_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .rf_reg_write_en(rf_reg_write_en), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [4:0]  rd;
    logic [63:0] d;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int fails = 0;
  bit mlg_b = 1'b1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  task automatic step(input logic av, input logic [4:0] ard,
                      input logic [63:0] ad, input logic bv,
                      input logic [4:0] brd, input logic [63:0] bd,
                      input logic iv, input logic [4:0] ird,
                      input logic r, output logic ga, output logic gb);
    @(negedge clk);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    issue_valid = iv; issue_rd = ird; rst = r;
    #1;
    ga = 1'b0;
    gb = 1'b0;
    if (!r) begin
      if (av && bv) begin
        if (mlg_b) ga = 1'b1;
        else gb = 1'b1;
      end else if (av) ga = 1'b1;
      else if (bv) gb = 1'b1;
    end
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    if (ga) begin
      mlg_b = 1'b0;
      if (ard != 0) q.push_back('{cyc + 1, ard, ad});
    end else if (gb) begin
      mlg_b = 1'b1;
      if (brd != 0) q.push_back('{cyc + 1, brd, bd});
    end
    if (r) mlg_b = 1'b1;
  endtask

  task automatic idle(input int n);
    logic ga, gb;
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
  endtask

  // monitor: compares write stage and scoreboard to the reference model
  initial begin : monitor
    logic [31:0] mb;
    logic [4:0]  mreg;
    logic [63:0] mdata;
    logic        exp_en;
    exp_t        e;
    mb = '0; mreg = '0; mdata = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      exp_en = 1'b0;
      if (q.size() > 0 && q[0].c == cyc) begin
        e = q.pop_front();
        exp_en = !rst;
        mreg = e.rd;
        mdata = e.d;
      end
      chk("rf_reg_write_en", rf_reg_write_en, exp_en);
      chk("rf_write_reg", rf_write_reg, mreg);
      chk("rf_write_data", rf_write_data, mdata);
      chk("busy", busy, mb);
      if (exp_en) mb[e.rd] = 1'b0;
      if (issue_valid && issue_rd != 0) mb[issue_rd] = 1'b1;
      if (rst) begin
        mb = '0; mreg = '0; mdata = '0;
      end
    end
  end

  initial begin : driver
    logic ga, gb;
    logic pa, pb;
    logic [4:0] ard, brd, ird;
    logic [63:0] ad, bd;
    logic iv, r;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, ga, gb);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, ga, gb);
    // contested stream alternates A,B,A,B
    for (int i = 0; i < 4; i++)
      step(1, 5, 64'h1111, 1, 6, 64'h2222, 0, 0, 0, ga, gb);
    idle(2);
    // issue then write-back of r7
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, ga, gb);
    idle(2);
    step(1, 7, 64'hDEAD, 0, 0, 0, 0, 0, 0, ga, gb);
    idle(2);
    // set/clear collision on r9, then disjoint r9 clear / r10 set
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, ga, gb);
    step(1, 9, 64'h99, 0, 0, 0, 0, 0, 0, ga, gb);
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, ga, gb);
    step(1, 9, 64'h999, 0, 0, 0, 0, 0, 0, ga, gb);
    step(0, 0, 0, 0, 0, 0, 1, 10, 0, ga, gb);
    idle(2);
    // x0 writes and issues are discarded
    step(0, 0, 0, 1, 0, 64'hFFFF, 0, 0, 0, ga, gb);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, ga, gb);
    idle(1);
    // reset right after an accepted transfer, then contested grant
    step(0, 0, 0, 1, 12, 64'hBEEF, 1, 12, 0, ga, gb);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, ga, gb);
    idle(1);
    step(1, 3, 64'h33, 1, 4, 64'h44, 0, 0, 0, ga, gb);
    chk("post_reset_grant_a", {63'd0, ga}, 64'd1);
    idle(1);
    // B alone three times, then contested: A wins
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 1, 11, 64'hB0 + i, 0, 0, 0, ga, gb);
    step(1, 13, 64'hA0, 1, 14, 64'hB9, 0, 0, 0, ga, gb);
    step(0, 0, 0, 1, 14, 64'hB9, 0, 0, 0, ga, gb);
    idle(2);
    // random traffic, sources hold until accepted
    pa = 0; pb = 0; ard = 0; brd = 0; ad = 0; bd = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!pa && $urandom_range(0, 9) < 6) begin
        pa = 1;
        ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        ad = {$urandom, $urandom};
      end
      if (!pb && $urandom_range(0, 9) < 6) begin
        pb = 1;
        brd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        bd = {$urandom, $urandom};
      end
      iv = 1'($urandom);
      ird = 5'($urandom);
      r = ($urandom_range(0, 99) == 0);
      step(pa, ard, ad, pb, brd, bd, iv, ird, r, ga, gb);
      if (ga) pa = 0;
      if (gb) pb = 0;
    end
    idle(3);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
